// File: rtl/center_pwm_if.sv
// Bundles the upstream step/compare inputs and the gate-drive outputs
// of the centre-aligned PWM stage.
interface center_pwm_if #(
  parameter int N = 8
) ();

  // Upstream step enable, shared with the triangle counter
  logic         ena;
  // Triangle value: 0 up to 2^N-1 and back down
  logic [N-1:0] tri_in;
  // Requested compare threshold and its one-cycle write strobe
  logic [N-1:0] duty;
  logic         duty_wr;

  // High-side and low-side gate drives
  logic         pwm_h;
  logic         pwm_l;
  // One-cycle pulse after each valley update
  logic         period_start;
  // Shadow register holds a value not yet applied
  logic         duty_pending;

  // Driver side: the triangle source and the duty writer
  modport master (
    output ena, tri_in, duty, duty_wr,
    input  pwm_h, pwm_l, period_start, duty_pending
  );

  // The PWM stage itself
  modport slave (
    input  ena, tri_in, duty, duty_wr,
    output pwm_h, pwm_l, period_start, duty_pending
  );

endinterface

// File: rtl/center_pwm.sv
// Centre-aligned PWM with a valley-updated duty register and a
// dead-time FSM that keeps the high and low side drives apart.
//
// The duty request is captured into a shadow register at any time and
// only copied to the active compare value at the triangle valley, so
// every period is symmetric. A registered compare (raw_q) feeds a
// four-state FSM that inserts DEAD clk cycles of both-off before the
// high side is allowed to turn on. DEAD must be within 1..255.
module center_pwm #(
  parameter int N    = 8,
  parameter int DEAD = 4
) (
  input  logic       clk,
  input  logic       rst,
  center_pwm_if.slave bus
);

  // Dead-time counter is 8 bits wide, enough for the full 1..255 range
  localparam logic [7:0] DEAD_CNT = 8'(DEAD);

  typedef enum logic [1:0] {
    LOW_ON,
    DEAD_TO_HIGH,
    HIGH_ON,
    DEAD_TO_LOW
  } state_t;

  // Duty path
  logic [N-1:0] shadow;
  logic [N-1:0] duty_active;
  logic         pending;
  logic         period_start_q;
  logic         valley;

  // Compare result
  logic         raw_q;

  // FSM
  state_t       state_q;
  state_t       state_d;
  logic [7:0]   cnt_q;
  logic [7:0]   cnt_d;

  // Registered drives
  logic         pwm_h_d;
  logic         pwm_l_d;
  logic         pwm_h_q;
  logic         pwm_l_q;

  // A valley is a step of the triangle that lands on zero. While ena is
  // low the upstream counter holds its value, so a zero held across
  // several idle cycles still yields exactly one valley.
  assign valley = bus.ena && (bus.tri_in == '0);

  // Shadow capture, valley update of the active duty and the period pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow         <= '0;
      duty_active    <= '0;
      pending        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make duty_active take the shadow
      // value from before this edge, even when duty_wr writes shadow on
      // the same edge as the valley.
      if (valley) begin
        duty_active <= shadow;
      end
      if (bus.duty_wr) begin
        shadow <= bus.duty;
      end
      // A write coinciding with the valley leaves the new value pending
      if (bus.duty_wr) begin
        pending <= 1'b1;
      end else if (valley) begin
        pending <= 1'b0;
      end
      period_start_q <= valley;
    end
  end

  // Unsigned compare, registered every clk regardless of ena
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= 1'b0;
    end else begin
      raw_q <= (bus.tri_in < duty_active);
    end
  end

  // FSM state and dead-time counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEAD_TO_LOW;
      cnt_q   <= DEAD_CNT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: every path into HIGH_ON passes through a full
  // DEAD_TO_HIGH countdown, so the high side always sees DEAD cycles of
  // both-off before it turns on.
  always_comb begin
    // NOTE: defaults first so that every path assigns both outputs and no
    // latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW_ON: begin
        if (raw_q) begin
          state_d = DEAD_TO_HIGH;
          cnt_d   = DEAD_CNT;
        end
      end
      DEAD_TO_HIGH: begin
        if (!raw_q) begin
          state_d = LOW_ON;
        end else if (cnt_q == 8'd1) begin
          state_d = HIGH_ON;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HIGH_ON: begin
        if (!raw_q) begin
          state_d = DEAD_TO_LOW;
          cnt_d   = DEAD_CNT;
        end
      end
      DEAD_TO_LOW: begin
        if (raw_q) begin
          // Restart the dead time rather than jumping straight to HIGH_ON
          state_d = DEAD_TO_HIGH;
          cnt_d   = DEAD_CNT;
        end else if (cnt_q == 8'd1) begin
          state_d = LOW_ON;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = DEAD_TO_LOW;
        cnt_d   = DEAD_CNT;
      end
    endcase
  end

  // Moore output decode, taken from the next state so the registered
  // drives line up exactly with the state register
  always_comb begin
    pwm_h_d = (state_d == HIGH_ON);
    pwm_l_d = (state_d == LOW_ON);
  end

  // Glitch-free registered gate drives
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
    end
  end

  assign bus.pwm_h        = pwm_h_q;
  assign bus.pwm_l        = pwm_l_q;
  assign bus.period_start = period_start_q;
  assign bus.duty_pending = pending;

  // Shoot-through guard: both sides must never be driven together
  a_no_overlap : assert property (@(posedge clk) disable iff (rst)
    !(pwm_h_q && pwm_l_q));

endmodule
